// File: rtl/stream_bus_demux_pkg.sv
// Shared constants and width helpers for the stream_bus_demux block.
package stream_bus_demux_pkg;

   localparam int CNT_W = 16;

   function automatic int sel_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   function automatic int ptr_w(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/stream_bus_demux_fifo.sv
// Per-channel FIFO for stream_bus_demux: DEPTH entries, no bypass, head always on dout.
module stream_bus_demux_fifo
   import stream_bus_demux_pkg::*;
#(
   parameter int BUS_WIDTH = 8,
   parameter int DEPTH     = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [BUS_WIDTH-1:0] din,
   output logic                 full,
   input  logic                 pop,
   output logic [BUS_WIDTH-1:0] dout,
   output logic                 empty
);

   localparam int PTR_W    = ptr_w(DEPTH);
   localparam int CNT_BITS = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0]    LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);

   logic [BUS_WIDTH-1:0] mem_q [DEPTH];
   logic [BUS_WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_BITS-1:0]  count_q, count_d;
   logic                 do_push, do_pop;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign dout    = mem_q[rd_ptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      // Push and pop together leave the occupancy unchanged.
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/stream_bus_demux.sv
// Registered 1-to-NUM_CH valid/ready demux with a FIFO per channel.
// Define STREAM_BUS_DEMUX_CNT_EN to add the CNT port with per-channel delivered-beat counters.
module stream_bus_demux
   import stream_bus_demux_pkg::*;
#(
   parameter int BUS_WIDTH = 8,
   parameter int NUM_CH    = 4,
   parameter int DEPTH     = 2
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [BUS_WIDTH-1:0]          Y,
   input  logic [sel_w(NUM_CH)-1:0]      SEL,
   input  logic                          Y_VALID,
   output logic                          Y_READY,
   output logic [NUM_CH*BUS_WIDTH-1:0]   DOUT,
   output logic [NUM_CH-1:0]             DOUT_VALID,
   input  logic [NUM_CH-1:0]             DOUT_READY,
   output logic                          SEL_ERR
`ifdef STREAM_BUS_DEMUX_CNT_EN
   ,
   output logic [NUM_CH*CNT_W-1:0]       CNT
`endif
);

   localparam int SEL_W = sel_w(NUM_CH);
   localparam logic [SEL_W:0] NUM_CH_EXT = (SEL_W + 1)'(NUM_CH);

   logic              sel_ok;
   logic [NUM_CH-1:0] hit_v, full_v, empty_v, push_v, pop_v;
   logic              sel_err_q, sel_err_d;

   assign sel_ok = ({1'b0, SEL} < NUM_CH_EXT);

   // Out-of-range selects hit no channel, so Y_READY falls back to 1 and the beat is dropped.
   always_comb begin
      hit_v = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         hit_v[c] = sel_ok && (SEL == SEL_W'(c));
      end
   end

   assign Y_READY   = ~|(hit_v & full_v);
   assign push_v    = hit_v & {NUM_CH{Y_VALID & Y_READY}};
   assign pop_v     = DOUT_VALID & DOUT_READY;
   assign sel_err_d = sel_err_q | (Y_VALID & ~sel_ok);
   assign SEL_ERR   = sel_err_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) sel_err_q <= 1'b0;
      else     sel_err_q <= sel_err_d;
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      stream_bus_demux_fifo #(
         .BUS_WIDTH (BUS_WIDTH),
         .DEPTH     (DEPTH)
      ) u_fifo (
         .clk   (CLK),
         .rst   (RST),
         .push  (push_v[c]),
         .din   (Y),
         .full  (full_v[c]),
         .pop   (pop_v[c]),
         .dout  (DOUT[c*BUS_WIDTH +: BUS_WIDTH]),
         .empty (empty_v[c])
      );
      assign DOUT_VALID[c] = ~empty_v[c];
   end

`ifdef STREAM_BUS_DEMUX_CNT_EN
   logic [CNT_W-1:0] cnt_q [NUM_CH];
   logic [CNT_W-1:0] cnt_d [NUM_CH];

   always_comb begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         cnt_d[c] = cnt_q[c] + CNT_W'(pop_v[c]);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            cnt_q[c] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt
      assign CNT[c*CNT_W +: CNT_W] = cnt_q[c];
   end
`endif

endmodule

// File: tb/tb_stream_bus_demux.sv
// Scoreboard bench for stream_bus_demux (4-channel instance plus a 3-channel instance for SEL range).
module tb_stream_bus_demux;

   typedef logic [7:0] beat_q_t[$];

   logic        clk, rst;
   logic [7:0]  y;
   logic [1:0]  sel;
   logic        y_valid, y_ready;
   logic [31:0] dout;
   logic [3:0]  dout_valid, dout_ready;
   logic        sel_err;
   logic [63:0] cnt;

   logic [7:0]  y3;
   logic [1:0]  sel3;
   logic        y_valid3, y_ready3;
   logic [23:0] dout3;
   logic [2:0]  dout_valid3, dout_ready3;
   logic        sel_err3;
   logic [47:0] cnt3;

   beat_q_t sb [4];
   int n_checks = 0;
   int n_fail   = 0;

   stream_bus_demux #(.BUS_WIDTH(8), .NUM_CH(4), .DEPTH(2)) dut (
      .CLK(clk), .RST(rst), .Y(y), .SEL(sel), .Y_VALID(y_valid), .Y_READY(y_ready),
      .DOUT(dout), .DOUT_VALID(dout_valid), .DOUT_READY(dout_ready), .SEL_ERR(sel_err)
`ifdef STREAM_BUS_DEMUX_CNT_EN
      , .CNT(cnt)
`endif
   );

   stream_bus_demux #(.BUS_WIDTH(8), .NUM_CH(3), .DEPTH(2)) dut3 (
      .CLK(clk), .RST(rst), .Y(y3), .SEL(sel3), .Y_VALID(y_valid3), .Y_READY(y_ready3),
      .DOUT(dout3), .DOUT_VALID(dout_valid3), .DOUT_READY(dout_ready3), .SEL_ERR(sel_err3)
`ifdef STREAM_BUS_DEMUX_CNT_EN
      , .CNT(cnt3)
`endif
   );

`ifndef STREAM_BUS_DEMUX_CNT_EN
   assign cnt  = '0;
   assign cnt3 = '0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: a handshake seen at the falling edge completes at the next rising edge.
   always @(negedge clk) begin
      if (!rst) begin
         for (int c = 0; c < 4; c++) begin
            if (dout_valid[c] && dout_ready[c]) begin
               n_checks++;
               if (sb[c].size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_beat ch%0d: got %0d expected none", c, dout[c*8 +: 8]);
               end else begin
                  logic [7:0] exp_v;
                  exp_v = sb[c].pop_front();
                  if (dout[c*8 +: 8] !== exp_v) begin
                     n_fail++;
                     $display("FAIL beat ch%0d: got %0d expected %0d", c, dout[c*8 +: 8], exp_v);
                  end
               end
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Entered and left at posedge+1; the beat is recorded in the scoreboard when accepted.
   task automatic beat(input logic [1:0] s, input logic [7:0] d);
      int waits;
      y       = d;
      sel     = s;
      y_valid = 1'b1;
      waits   = 0;
      @(negedge clk);
      while (!y_ready && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      if (!y_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout ch%0d: got ready=0 expected ready=1", s);
      end else begin
         sb[s].push_back(d);
      end
      @(posedge clk);
      #1;
      y_valid = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      y = '0; sel = '0; y_valid = 1'b0; dout_ready = 4'hF;
      y3 = '0; sel3 = '0; y_valid3 = 1'b0; dout_ready3 = 3'h7;
      #3;
      check("rst_dout_valid", dout_valid, 0);
      check("rst_y_ready", y_ready, 1);
      check("rst_dout", dout, 0);
      check("rst_sel_err", sel_err, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      cycles(1);
      check("idle_dout_valid", dout_valid, 0);
      check("idle_y_ready", y_ready, 1);
      check("idle_sel_err", sel_err, 0);

      // One beat per channel on consecutive cycles, all consumers ready.
      for (int s = 0; s < 4; s++) begin
         beat(2'(s), 8'd123);
         check($sformatf("t1_onehot_%0d", s), dout_valid, 64'(1 << s));
         check($sformatf("t1_dout_%0d", s), dout[s*8 +: 8], 123);
      end
      cycles(2);
      check("t1_drained", dout_valid, 0);

      // Fill channel 2 while its consumer stalls.
      dout_ready = 4'b1011;
      beat(2'd2, 8'd10);
      beat(2'd2, 8'd11);
      sel = 2'd2;
      #1 check("t2_ready_full_ch", y_ready, 0);
      sel = 2'd1;
      #1 check("t2_ready_other_ch", y_ready, 1);
      check("t2_valid", dout_valid, 4'b0100);
      @(posedge clk);
      #1 dout_ready = 4'hF;
      cycles(3);
      check("t2_drained", dout_valid, 0);

      // Channel 0 full, pop on 0 and push to 3 in the same cycle.
      dout_ready = 4'b1110;
      beat(2'd0, 8'd20);
      beat(2'd0, 8'd21);
      dout_ready = 4'b0111;
      beat(2'd3, 8'd33);
      dout_ready = 4'b0110;
      check("t3_ch0_valid", dout_valid[0], 1);
      check("t3_ch0_head", dout[7:0], 21);
      check("t3_ch3_valid", dout_valid[3], 1);
      check("t3_ch3_head", dout[31:24], 33);
      sel = 2'd0;
      #1 check("t3_ch0_not_full", y_ready, 1);
      @(posedge clk);
      #1 dout_ready = 4'hF;
      cycles(3);
      check("t3_drained", dout_valid, 0);

      // Out-of-range select on the 3-channel instance.
      y3 = 8'd77; sel3 = 2'd3; y_valid3 = 1'b1;
      @(negedge clk);
      check("t4_ready", y_ready3, 1);
      check("t4_err_before", sel_err3, 0);
      @(posedge clk);
      #1 y_valid3 = 1'b0;
      check("t4_err_set", sel_err3, 1);
      check("t4_no_valid", dout_valid3, 0);
      cycles(3);
      check("t4_err_sticky", sel_err3, 1);
      check("t4_no_valid_later", dout_valid3, 0);
      check("t4_dut0_err", sel_err, 0);

      // Mid-stream reset flushes channel 1.
      dout_ready = 4'b1101;
      beat(2'd1, 8'd50);
      beat(2'd1, 8'd51);
      check("t5_loaded", dout_valid, 4'b0010);
      rst = 1'b1;
      sb[1].delete();
      #1;
      check("t5_valid_in_rst", dout_valid, 0);
      check("t5_dout_in_rst", dout, 0);
      check("t5_ready_in_rst", y_ready, 1);
      check("t5_err3_cleared", sel_err3, 0);
      dout_ready = 4'hF;
      @(posedge clk);
      #1 rst = 1'b0;
      cycles(5);
      check("t5_no_delivery", dout_valid, 0);

`ifdef STREAM_BUS_DEMUX_CNT_EN
      check("cnt_after_rst", cnt, 0);
      for (int i = 0; i < 5; i++) beat(2'd1, 8'(100 + i));
      cycles(2);
      check("cnt_five", cnt, 64'h0000_0000_0005_0000);
      for (int i = 0; i < 65530; i++) beat(2'd1, 8'(i));
      cycles(2);
      check("cnt_ffff", cnt[31:16], 16'hFFFF);
      beat(2'd1, 8'd200);
      cycles(2);
      check("cnt_wrap", cnt, 0);
`endif

      for (int c = 0; c < 4; c++) begin
         check($sformatf("sb_empty_%0d", c), sb[c].size(), 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
